// File: rtl/score_disp_pkg.sv
// score_disp_pkg: segment codes, FSM encoding and BCD helpers shared by the score display path.
package score_disp_pkg;

    localparam int BCD_DIGITS = 4;

    // Active-low segments, bit0=a .. bit6=g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift
    function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] b);
        logic [4*BCD_DIGITS-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++)
            r[4*i+:4] = b[4*i+:4] >= 4'd5 ? b[4*i+:4] + 4'd3 : b[4*i+:4];
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: one BCD digit plus blank flag to a 7-bit active-low segment pattern.
module bcd_to_seg
    import score_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i)
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
    end

endmodule

// File: rtl/score_seg_encoder.sv
// score_seg_encoder: sequential double-dabble of the score into a four-digit segment bus, updated atomically.
module score_seg_encoder
    import score_disp_pkg::*;
#(
    parameter int SCORE_W       = 14,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               busy,
    output logic               done,
    output logic [27:0]        display_all
);

    localparam int CNT_W = $clog2(SCORE_W + 1);
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam logic [27:0] DISP_RST = BLANK_LEADING ? {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0}
                                                     : {SEG_0, SEG_0, SEG_0, SEG_0};

    state_t             state_q;
    logic               busy_q, done_q, pend_q;
    logic [SCORE_W-1:0] pend_val_q, bin_q, src, sat_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [27:0]        disp_q, disp_d;
    logic [3:0]         blank;

    // A fresh request in the same cycle beats an older pending one
    assign src   = score_valid ? score : pend_val_q;
    assign sat_d = 32'(src) > 32'd9999 ? SCORE_W'(9999) : src;
    assign bcd_d = bcd_adjust(bcd_q);

    always_comb begin
        blank    = '0;
        blank[3] = BLANK_LEADING && bcd_q[15:12] == 4'd0;
        blank[2] = blank[3] && bcd_q[11:8] == 4'd0;
        blank[1] = blank[2] && bcd_q[7:4] == 4'd0;
    end

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_seg
        bcd_to_seg u_seg (
            .bcd_i  (bcd_q[4*i+:4]),
            .blank_i(blank[i]),
            .seg_o  (disp_d[7*i+:7])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            disp_q     <= DISP_RST;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (score_valid || pend_q) begin
                        bin_q   <= sat_d;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_d[BCD_W-2:0], bin_q, 1'b0};
                    cnt_q          <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SCORE_W - 1))
                        state_q <= LATCH;
                    if (score_valid) begin
                        pend_q     <= 1'b1;
                        pend_val_q <= score;
                    end
                end
                LATCH: begin
                    disp_q  <= disp_d;
                    done_q  <= 1'b1;
                    busy_q  <= pend_q || score_valid;
                    state_q <= IDLE;
                    if (score_valid) begin
                        pend_q     <= 1'b1;
                        pend_val_q <= score;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign display_all = disp_q;

endmodule

// File: tb/tb_score_seg_encoder.sv
// tb_score_seg_encoder: table and sequence checks of score_seg_encoder with a done-driven scoreboard.
module tb_score_seg_encoder;

    localparam logic [6:0] SEG_T [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] BL = 7'h7F;

    typedef struct {
        int          v;
        logic [27:0] e_b;
        logic [27:0] e_z;
    } exp_t;

    typedef struct {
        int          v;
        logic [27:0] e_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] score = '0;
    logic        score_valid = 1'b0;
    logic        busy_b, done_b, busy_z, done_z;
    logic [27:0] disp_b, disp_z;
    int          checks = 0;
    int          failures = 0;
    exp_t        q[$];

    always #5 clk = ~clk;

    score_seg_encoder #(.SCORE_W(14), .BLANK_LEADING(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
        .busy(busy_b), .done(done_b), .display_all(disp_b)
    );

    score_seg_encoder #(.SCORE_W(14), .BLANK_LEADING(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .score(score), .score_valid(score_valid),
        .busy(busy_z), .done(done_z), .display_all(disp_z)
    );

    function automatic logic [27:0] pack(logic [6:0] t, logic [6:0] h, logic [6:0] n, logic [6:0] o);
        return {t, h, n, o};
    endfunction

    // Independent decimal model: saturate, split by division, blank leading zeros
    function automatic logic [27:0] model(int v, bit blank_lead);
        logic [27:0] r;
        int          d;
        bit          lead;
        if (v > 9999) v = 9999;
        lead = blank_lead;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            d = (v / (10 ** i)) % 10;
            if (lead && d == 0 && i != 0) r[7*i+:7] = BL;
            else begin
                r[7*i+:7] = SEG_T[d];
                lead = 1'b0;
            end
        end
        return r;
    endfunction

    task automatic chk(string n, logic [27:0] a, logic [27:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (done_b || done_z) begin
            if (q.size() == 0) chk("unexpected_done", {27'd0, done_b}, 28'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk($sformatf("disp_b_%0d", e.v), disp_b, e.e_b);
                chk($sformatf("disp_z_%0d", e.v), disp_z, e.e_z);
                chk($sformatf("done_pair_%0d", e.v), {26'd0, done_b, done_z}, 28'd3);
            end
        end
    end

    task automatic pulse(int v, bit expect_out, logic [27:0] e_b);
        score = 14'(v);
        score_valid = 1'b1;
        if (expect_out) q.push_back('{v, e_b, model(v, 1'b0)});
        @(negedge clk);
        score_valid = 1'b0;
    endtask

    task automatic drain(string n);
        int i;
        for (i = 0; i < 25 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            chk({n, "_timeout"}, 28'(q.size()), 28'd0);
            q.delete();
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{9999,  pack(7'h10, 7'h10, 7'h10, 7'h10)};
        vecs[1] = '{12000, pack(7'h10, 7'h10, 7'h10, 7'h10)};
        vecs[2] = '{7,     pack(BL, BL, BL, 7'h78)};
        vecs[3] = '{1005,  pack(7'h79, 7'h40, 7'h40, 7'h12)};
        vecs[4] = '{0,     pack(BL, BL, BL, 7'h40)};
        vecs[5] = '{16383, pack(7'h10, 7'h10, 7'h10, 7'h10)};
        vecs[6] = '{10,    pack(BL, BL, 7'h79, 7'h40)};
        vecs[7] = '{100,   pack(BL, 7'h79, 7'h40, 7'h40)};
        vecs[8] = '{1000,  pack(7'h79, 7'h40, 7'h40, 7'h40)};
        vecs[9] = '{909,   pack(BL, 7'h10, 7'h40, 7'h10)};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_disp_b", disp_b, pack(BL, BL, BL, 7'h40));
        chk("rst_disp_z", disp_z, pack(7'h40, 7'h40, 7'h40, 7'h40));
        chk("rst_busy_done", {26'd0, busy_b, done_b}, 28'd0);

        // Single conversion with exact busy/done timing
        pulse(1234, 1'b1, pack(7'h79, 7'h24, 7'h30, 7'h19));
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("busy_1234_k%0d", k), {27'd0, busy_b}, {27'd0, k <= 14});
            chk($sformatf("done_1234_k%0d", k), {27'd0, done_b}, {27'd0, k == 15});
        end
        drain("c1234");

        foreach (vecs[i]) begin
            pulse(vecs[i].v, 1'b1, vecs[i].e_b);
            drain($sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Back-to-back: 42, then 17 overwritten by 99 while busy
        pulse(42, 1'b1, pack(BL, BL, 7'h19, 7'h24));
        for (int k = 1; k <= 32; k++) begin
            if (k == 2) begin
                score = 14'd17;
                score_valid = 1'b1;
            end else if (k == 4) begin
                score = 14'd99;
                score_valid = 1'b1;
                q.push_back('{99, pack(BL, BL, 7'h10, 7'h10), model(99, 1'b0)});
            end
            @(negedge clk);
            score_valid = 1'b0;
            chk($sformatf("b2b_busy_k%0d", k), {27'd0, busy_b}, {27'd0, k <= 30});
            chk($sformatf("b2b_done_k%0d", k), {27'd0, done_b}, {27'd0, k == 15 || k == 31});
        end
        drain("b2b");

        // Reset in the middle of a conversion discards it without a done pulse
        pulse(555, 1'b0, '0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_disp_b", disp_b, pack(BL, BL, BL, 7'h40));
        chk("midrst_disp_z", disp_z, pack(7'h40, 7'h40, 7'h40, 7'h40));
        chk("midrst_busy", {27'd0, busy_b}, 28'd0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_done", {27'd0, done_b}, 28'd0);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("postrst_disp_b", disp_b, pack(BL, BL, BL, 7'h40));

        pulse(3, 1'b1, pack(BL, BL, BL, 7'h30));
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk($sformatf("done_3_k%0d", k), {27'd0, done_b}, {27'd0, k == 15});
        end
        drain("c3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
